// File: rtl/dl_ram_writer_if.sv
// Bus between the download engine, the download RAM writer and the RAM controller's download port.
interface dl_ram_writer_if #(
  parameter int unsigned AW = 25
);
  logic          in_wr;
  logic [AW-1:0] in_addr;
  logic [7:0]    in_data;
  logic          ram_req;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_dout;
  logic          ram_ack;
  logic          busy;
  logic          overflow;

  // Environment side: download engine strobes plus the RAM controller's ack
  modport master (
    output in_wr, in_addr, in_data, ram_ack,
    input  ram_req, ram_addr, ram_dout, busy, overflow
  );

  modport slave (
    input  in_wr, in_addr, in_data, ram_ack,
    output ram_req, ram_addr, ram_dout, busy, overflow
  );
endinterface

// File: rtl/dl_ram_writer.sv
// Buffers download/erase byte writes in a small FIFO and replays them to the RAM download port via req/ack.
// Optional macro DL_RAM_WRITER_STATS_EN adds saturating wr_count/drop_count outputs.
module dl_ram_writer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 25
) (
  input  logic           clk,
  input  logic           reset,
  dl_ram_writer_if.slave bus
`ifdef DL_RAM_WRITER_STATS_EN
  ,
  output logic [23:0]    wr_count,
  output logic [15:0]    drop_count
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t        state, state_n;
  logic [AW-1:0] addr_mem [DEPTH];
  logic [7:0]    data_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n;
  logic          push, pop, drop, load, ram_req_n;

  // FIFO push/pop/drop decisions; a pop frees a slot for a same-cycle push
  always_comb begin
    pop     = (state == REQ) && bus.ram_ack;
    push    = bus.in_wr && ((count < CW'(DEPTH)) || pop);
    drop    = bus.in_wr && !push;
    count_n = count;
    if (push && !pop) begin
      count_n = count + CW'(1);
    end else if (pop && !push) begin
      count_n = count - CW'(1);
    end
  end

  // Request sequencer; GAP forces a low phase between consecutive requests
  always_comb begin
    state_n = state;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          state_n = REQ;
          load    = 1'b1;
        end
      end
      REQ: begin
        if (bus.ram_ack) begin
          state_n = GAP;
        end
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    ram_req_n = (state_n == REQ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      bus.ram_req  <= 1'b0;
      bus.ram_addr <= '0;
      bus.ram_dout <= '0;
      bus.busy     <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count       <= count_n;
      bus.ram_req <= ram_req_n;
      if (load) begin
        bus.ram_addr <= addr_mem[rd_ptr];
        bus.ram_dout <= data_mem[rd_ptr];
      end
      bus.busy <= (count != '0) || bus.ram_req;
      if (drop) begin
        bus.overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset; the pointers and count define which slots are valid
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= bus.in_addr;
      data_mem[wr_ptr] <= bus.in_data;
    end
  end

`ifdef DL_RAM_WRITER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_count   <= '0;
      drop_count <= '0;
    end else begin
      if (pop && (wr_count != '1)) begin
        wr_count <= wr_count + 24'd1;
      end
      if (drop && (drop_count != '1)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dl_ram_writer.sv
// Self-checking bench for dl_ram_writer: vector table of write streams plus hand-written corner sequences.
module tb_dl_ram_writer;
  localparam int unsigned AW    = 25;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dl_ram_writer_if #(.AW(AW)) bus ();

`ifdef DL_RAM_WRITER_STATS_EN
  logic [23:0] wr_count;
  logic [15:0] drop_count;
`endif

  dl_ram_writer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus)
`ifdef DL_RAM_WRITER_STATS_EN
    ,
    .wr_count  (wr_count),
    .drop_count(drop_count)
`endif
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  typedef struct {
    string         name;
    int            n;
    logic [AW-1:0] base;
    logic [7:0]    dbase;
    int            dstep;
    int            spacing;
    int            lat;
    int            hold;
    int            exp_writes;
    int            exp_ovf;
    int            exp_maxocc;
  } row_t;

  row_t rows[4];
  wr_t  q[$];
  int   tests = 0;
  int   fails = 0;
  int   ack_lat = 0;
  int   hold = 0;
  int   n_acked = 0;
  int   m_drops = 0;
  int   max_occ = 0;
  bit   ack_en = 1'b0;
  bit   force_ack = 1'b0;
  bit   m_ovf = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // RAM controller model: acks after ack_lat cycles of ram_req and scores each write
  initial begin : responder
    int  wait_cnt;
    int  low_cnt;
    bit  prev_req;
    wr_t cap;
    wr_t exp;
    wait_cnt    = 0;
    low_cnt     = 100;
    prev_req    = 1'b0;
    cap         = '0;
    bus.ram_ack = 1'b0;
    forever begin
      @(negedge clk);
      bus.ram_ack = 1'b0;
      if (hold > 0) hold--;
      if ((bus.ram_req === 1'b1) && !prev_req) begin
        check("req_low_gap", 32'(low_cnt >= 2), 1);
        cap = {bus.ram_addr, bus.ram_dout};
      end
      if (bus.ram_req === 1'b1) low_cnt = 0;
      else low_cnt++;
      prev_req = (bus.ram_req === 1'b1);
      if (force_ack) begin
        bus.ram_ack = 1'b1;
        force_ack   = 1'b0;
      end else if ((bus.ram_req === 1'b1) && ack_en && (hold == 0)) begin
        if (wait_cnt >= ack_lat) begin
          wait_cnt    = 0;
          bus.ram_ack = 1'b1;
          n_acked++;
          check("req_stable", 32'({bus.ram_addr, bus.ram_dout} == cap), 1);
          check("req_unexpected", 32'(q.size() == 0), 0);
          if (q.size() != 0) begin
            exp = q.pop_front();
            check("ram_addr", 32'(bus.ram_addr), 32'(exp.addr));
            check("ram_dout", 32'(bus.ram_dout), 32'(exp.data));
          end
        end else begin
          wait_cnt++;
        end
      end
      if (bus.ram_req !== 1'b1) wait_cnt = 0;
    end
  end

  task automatic strobe(input logic [AW-1:0] a, input logic [7:0] d);
    bus.in_wr   = 1'b1;
    bus.in_addr = a;
    bus.in_data = d;
    if (q.size() < DEPTH) begin
      q.push_back({a, d});
      if (q.size() > max_occ) max_occ = q.size();
    end else begin
      m_ovf = 1'b1;
      m_drops++;
    end
    step();
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    bus.in_wr = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    bus.in_wr = 1'b0;
    ack_en    = 1'b0;
    force_ack = 1'b0;
    hold      = 0;
    step();
    step();
    q.delete();
    m_ovf   = 1'b0;
    m_drops = 0;
    n_acked = 0;
    max_occ = 0;
    reset   = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((q.size() != 0 || bus.busy !== 1'b0 || bus.ram_req !== 1'b0) && t < 5000) begin
      step();
      t++;
    end
    check({name, "_timeout"}, 32'(t >= 5000), 0);
    repeat (4) step();
  endtask

  task automatic check_stats(input string name);
`ifdef DL_RAM_WRITER_STATS_EN
    check({name, "_wr_count"}, 32'(wr_count), 32'(n_acked));
    check({name, "_drop_count"}, 32'(drop_count), 32'(m_drops));
`else
    check({name, "_no_stats_ovf"}, 32'(bus.overflow), 32'(m_ovf));
`endif
  endtask

  initial begin
    bit seen_req;
    reset       = 1'b1;
    bus.in_wr   = 1'b0;
    bus.in_addr = '0;
    bus.in_data = '0;

    rows[0] = '{"single", 1,   25'h170000, 8'hF3, 1, 1,  2, 0,  1,   0, 1};
    rows[1] = '{"burst",  8,   25'h400000, 8'h00, 1, 1,  0, 20, 8,   0, 8};
    rows[2] = '{"ovf",    10,  25'h020000, 8'h10, 1, 1,  1, 30, 8,   1, 8};
    rows[3] = '{"erase",  256, 25'h1a0000, 8'h00, 0, 32, 5, 0,  256, 0, 1};

    do_reset();
    check("rst_ram_req", 32'(bus.ram_req), 0);
    check("rst_ram_addr", 32'(bus.ram_addr), 0);
    check("rst_ram_dout", 32'(bus.ram_dout), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_overflow", 32'(bus.overflow), 0);

    // Latency of a single write and busy release after the ack
    strobe(25'h170000, 8'hF3);
    check("lat_req_edge_n", 32'(bus.ram_req), 0);
    step();
    check("lat_req_edge_n1", 32'(bus.ram_req), 1);
    check("lat_addr", 32'(bus.ram_addr), 32'h170000);
    check("lat_dout", 32'(bus.ram_dout), 32'hF3);
    check("lat_busy", 32'(bus.busy), 1);
    ack_lat = 0;
    ack_en  = 1'b1;
    step();
    step();
    check("ack_req_drop", 32'(bus.ram_req), 0);
    check("ack_count", 32'(n_acked), 1);
    step();
    step();
    check("ack_busy_clear", 32'(bus.busy), 0);
    check("ack_overflow", 32'(bus.overflow), 0);

    foreach (rows[r]) begin
      do_reset();
      ack_lat = rows[r].lat;
      hold    = rows[r].hold;
      ack_en  = 1'b1;
      for (int k = 0; k < rows[r].n; k++) begin
        strobe(AW'(rows[r].base + AW'(k)), 8'(rows[r].dbase + 8'(k * rows[r].dstep)));
        repeat (rows[r].spacing - 1) step();
      end
      drain(rows[r].name);
      check({rows[r].name, "_writes"}, 32'(n_acked), 32'(rows[r].exp_writes));
      check({rows[r].name, "_ovf"}, 32'(bus.overflow), 32'(rows[r].exp_ovf));
      check({rows[r].name, "_maxocc"}, 32'(max_occ), 32'(rows[r].exp_maxocc));
      check({rows[r].name, "_busy"}, 32'(bus.busy), 0);
      check_stats(rows[r].name);
    end

    // Full FIFO: strobe coinciding with an ack is accepted, the next one is dropped
    do_reset();
    ack_lat = 0;
    for (int k = 0; k < 8; k++) strobe(AW'(25'h0A0000 + AW'(k)), 8'(8'hA0 + 8'(k)));
    step();
    step();
    ack_en = 1'b1;
    step();
    strobe(25'h0A0008, 8'hA8);
    check("full_pop_ovf", 32'(bus.overflow), 0);
    ack_en = 1'b0;
    strobe(25'h0A0009, 8'hA9);
    check("full_stays_full", 32'(bus.overflow), 1);
    ack_en = 1'b1;
    drain("full_pop");
    check("full_pop_writes", 32'(n_acked), 9);
    check_stats("full_pop");

    // Reset pulse while requesting, then a stray ack in IDLE
    do_reset();
    for (int k = 0; k < 3; k++) strobe(AW'(25'h0B0000 + AW'(k)), 8'(8'hB0 + 8'(k)));
    step();
    check("midrst_pre_req", 32'(bus.ram_req), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    q.delete();
    check("midrst_req", 32'(bus.ram_req), 0);
    check("midrst_busy", 32'(bus.busy), 0);
    force_ack = 1'b1;
    ack_en    = 1'b1;
    seen_req  = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus.ram_req !== 1'b0) seen_req = 1'b1;
    end
    check("midrst_no_req", 32'(seen_req), 0);
    check("midrst_busy_after", 32'(bus.busy), 0);
    check("midrst_ovf", 32'(bus.overflow), 0);
`ifdef DL_RAM_WRITER_STATS_EN
    check("midrst_wr_count", 32'(wr_count), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
